// File: rtl/bpi_flash_sequencer.sv
// Sequences BPI flash command cycles (read-array, program, erase, read-status)
// over an AXI4-Lite master, polling the status register and reporting one response per command.
module bpi_flash_sequencer #(
  parameter int unsigned C_AXI_WIDTH  = 32,
  parameter int unsigned C_MEM_SIZE   = 134217728,
  parameter int unsigned C_POLL_LIMIT = 65535,
  localparam int unsigned A           = $clog2(C_MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [A-1:0]             cmd_addr,
  input  logic [15:0]              cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_code,
  output logic [7:0]               rsp_status,
  output logic [A-1:0]             m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [C_AXI_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_WIDTH/8-1:0] m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [A-1:0]             m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [C_AXI_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int unsigned PW = $clog2(C_POLL_LIMIT + 1);

  typedef enum logic [2:0] {StIdle, StAwW, StB, StAr, StR, StResp} state_e;
  typedef enum logic [1:0] {KWrite, KPoll, KRead, KEnd} kind_e;

  // What the sequence does at a given step of a given op.
  function automatic kind_e step_kind(input logic [1:0] op, input logic [2:0] step);
    kind_e k;
    k = KEnd;
    case (op)
      2'd0: if (step == 3'd0) k = KWrite;
      2'd1: begin
        if (step == 3'd3) k = KPoll;
        else if (step <= 3'd4) k = KWrite;
      end
      2'd2: begin
        if (step == 3'd5) k = KPoll;
        else if (step <= 3'd6) k = KWrite;
      end
      default: begin
        if (step == 3'd1) k = KRead;
        else if (step <= 3'd2) k = KWrite;
      end
    endcase
    return k;
  endfunction

  function automatic logic [15:0] step_data(input logic [1:0] op, input logic [2:0] step,
                                            input logic [15:0] data);
    logic [15:0] d;
    d = 16'h00FF;
    case (op)
      2'd1: begin
        case (step)
          3'd0:    d = 16'h0050;
          3'd1:    d = 16'h0040;
          3'd2:    d = data;
          default: d = 16'h00FF;
        endcase
      end
      2'd2: begin
        case (step)
          3'd0:    d = 16'h0050;
          3'd1:    d = 16'h0060;
          3'd2:    d = 16'h00D0;
          3'd3:    d = 16'h0020;
          3'd4:    d = 16'h00D0;
          default: d = 16'h00FF;
        endcase
      end
      2'd3:    if (step == 3'd0) d = 16'h0070;
      default: d = 16'h00FF;
    endcase
    return d;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [15:0]    data_q, data_d;
  logic [2:0]     step_q, step_d, step_nxt;
  logic [PW-1:0]  poll_cnt_q, poll_cnt_d, cnt_nxt;
  logic           awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [1:0]     code_q, code_d;
  logic [7:0]     status_q, status_d;
  logic           cmd_ready_q;
  logic           advance;
  logic [7:0]     rd_status;
  logic [15:0]    wr_half;
  logic           unused_rdata;

  assign rd_status    = addr_q[1] ? m_axi_rdata[23:16] : m_axi_rdata[7:0];
  assign unused_rdata = ^{m_axi_rdata[31:24], m_axi_rdata[15:8]};
  assign wr_half      = step_data(op_q, step_q, data_q);
  assign step_nxt     = step_q + 3'd1;
  assign cnt_nxt      = poll_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    code_d     = code_q;
    status_d   = status_q;
    advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr & ~A'(1);
          data_d     = cmd_data;
          step_d     = 3'd0;
          poll_cnt_d = '0;
          code_d     = 2'd0;
          status_d   = 8'h00;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_d    = StAwW;
        end
      end
      StAwW: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = StB;
      end
      StB: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            code_d  = 2'd3;
            state_d = StResp;
          end else begin
            advance = 1'b1;
          end
        end
      end
      StAr: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = StR;
        end
      end
      StR: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) begin
            code_d  = 2'd3;
            state_d = StResp;
          end else begin
            status_d = rd_status;
            if (step_kind(op_q, step_q) == KRead) begin
              advance = 1'b1;
            end else if (rd_status[7]) begin
              if ((rd_status & 8'h3A) != 8'h00 && code_q == 2'd0) code_d = 2'd1;
              advance = 1'b1;
            end else if (cnt_nxt >= PW'(C_POLL_LIMIT)) begin
              // Timed out: still return the array to read mode with the FF write.
              if (code_q == 2'd0) code_d = 2'd2;
              advance = 1'b1;
            end else begin
              poll_cnt_d = cnt_nxt;
              arvalid_d  = 1'b1;
              state_d    = StAr;
            end
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      step_d     = step_nxt;
      poll_cnt_d = '0;
      unique case (step_kind(op_q, step_nxt))
        KWrite: begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StAwW;
        end
        KPoll, KRead: begin
          arvalid_d = 1'b1;
          state_d   = StAr;
        end
        default: state_d = StResp;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      addr_q      <= '0;
      data_q      <= 16'h0000;
      step_q      <= 3'd0;
      poll_cnt_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      code_q      <= 2'd0;
      status_q    <= 8'h00;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      step_q      <= step_d;
      poll_cnt_q  <= poll_cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      code_q      <= code_d;
      status_q    <= status_d;
      cmd_ready_q <= (state_d == StIdle);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = (state_q == StResp);
  assign rsp_code      = code_q;
  assign rsp_status    = status_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = addr_q[1] ? {wr_half, 16'h0000} : {16'h0000, wr_half};
  assign m_axi_wstrb   = addr_q[1] ? 4'b1100 : 4'b0011;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == StB);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == StR);

endmodule

// File: tb/tb_bpi_flash_sequencer.sv
// Randomized bench: AXI slave with scripted status/error replies and a transaction-list model.
module tb_bpi_flash_sequencer;
  localparam int unsigned A   = 27;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [A-1:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_code;
  logic [7:0] rsp_status;
  logic [A-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready = 1'b0, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [31:0] m_axi_wdata, m_axi_rdata = '0;
  logic [3:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp = '0, m_axi_rresp = '0;
  logic m_axi_bvalid = 1'b0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1'b0;
  logic m_axi_rvalid = 1'b0, m_axi_rready;

  always #5 clk = ~clk;

  bpi_flash_sequencer #(.C_AXI_WIDTH(32), .C_MEM_SIZE(134217728), .C_POLL_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_status(rsp_status), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    bit          wr;
    logic [A-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t        exp_q[$];
  logic [1:0]  exp_code;
  logic [7:0]  exp_status;
  logic [7:0]  stat_arr[16];
  int          berr_idx = -1, rerr_idx = -1, wcnt = 0, rcnt = 0;
  bit          force_late = 1'b0, busy = 1'b0, chk_ready = 1'b0;
  int          vectors = 0, miscompares = 0;
  bit          m_dead;
  int          m_wi, m_ri;
  logic [A-1:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: expected AXI transaction list and response
  task automatic m_write(input logic [15:0] d);
    txn_t t;
    if (m_dead) return;
    t.wr = 1'b1;
    t.addr = m_addr;
    t.data = m_addr[1] ? {d, 16'h0000} : {16'h0000, d};
    t.strb = m_addr[1] ? 4'b1100 : 4'b0011;
    exp_q.push_back(t);
    if (m_wi == berr_idx) begin exp_code = 2'd3; m_dead = 1'b1; end
    m_wi++;
  endtask

  task automatic m_read();
    txn_t t;
    if (m_dead) return;
    t.wr = 1'b0; t.addr = m_addr; t.data = '0; t.strb = '0;
    exp_q.push_back(t);
    if (m_ri == rerr_idx) begin exp_code = 2'd3; m_dead = 1'b1; end
    else exp_status = stat_arr[m_ri];
    m_ri++;
  endtask

  task automatic m_poll();
    for (int n = 1; !m_dead; n++) begin
      m_read();
      if (m_dead) break;
      if (exp_status[7]) begin
        if ((exp_status & 8'h3A) != 8'h00) exp_code = 2'd1;
        break;
      end
      if (n == LIM) begin exp_code = 2'd2; break; end
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [A-1:0] addr, input logic [15:0] d);
    exp_q.delete();
    exp_code = 2'd0; exp_status = 8'h00;
    m_dead = 1'b0; m_wi = 0; m_ri = 0;
    m_addr = addr & ~A'(1);
    case (op)
      2'd0: m_write(16'h00FF);
      2'd1: begin
        m_write(16'h0050); m_write(16'h0040); m_write(d); m_poll(); m_write(16'h00FF);
      end
      2'd2: begin
        m_write(16'h0050); m_write(16'h0060); m_write(16'h00D0); m_write(16'h0020);
        m_write(16'h00D0); m_poll(); m_write(16'h00FF);
      end
      default: begin m_write(16'h0070); m_read(); m_write(16'h00FF); end
    endcase
  endtask

  // ---------------- AXI slave: compares each transaction against the model list
  task automatic cmp_txn(input txn_t got);
    txn_t e;
    check("txn_expected", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("txn_kind", e.wr, got.wr);
    check("txn_addr", got.addr, e.addr);
    if (got.wr) begin
      check("txn_wdata", got.data, e.data);
      check("txn_wstrb", got.strb, e.strb);
    end
  endtask

  task automatic do_write();
    int dw, da;
    bit aw_done, w_done, hs;
    txn_t got;
    check("aw_w_together", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    got.wr = 1'b1; got.addr = m_axi_awaddr; got.data = m_axi_wdata; got.strb = m_axi_wstrb;
    if (force_late) begin dw = 0; da = 3; end
    else begin dw = $urandom_range(0, 3); da = $urandom_range(0, 3); end
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      if (!rst_n) return;
      if (aw_done) check("awvalid_dropped", m_axi_awvalid, 0);
      if (w_done) check("wvalid_dropped", m_axi_wvalid, 0);
      m_axi_awready = !aw_done && (c >= da);
      m_axi_wready  = !w_done && (c >= dw);
      if (m_axi_awready && m_axi_awvalid) aw_done = 1'b1;
      if (m_axi_wready && m_axi_wvalid) w_done = 1'b1;
      @(negedge clk);
    end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    cmp_txn(got);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (!rst_n) return;
    end
    m_axi_bvalid = 1'b1;
    m_axi_bresp = (wcnt == berr_idx) ? 2'b10 : 2'b00;
    wcnt++;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      if (!rst_n) return;
      hs = m_axi_bready;
      @(negedge clk);
    end
    m_axi_bvalid = 1'b0;
    check("b_handshake", hs, 1);
  endtask

  task automatic do_read();
    int da;
    bit hs;
    txn_t got;
    logic [7:0] st;
    logic [31:0] junk;
    got.wr = 1'b0; got.addr = m_axi_araddr; got.data = '0; got.strb = '0;
    da = $urandom_range(0, 3);
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      if (!rst_n) return;
      m_axi_arready = (c >= da);
      hs = m_axi_arready && m_axi_arvalid;
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    check("ar_handshake", hs, 1);
    cmp_txn(got);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (!rst_n) return;
    end
    st = (rcnt < 16) ? stat_arr[rcnt] : 8'h00;
    junk = $urandom;
    m_axi_rdata = got.addr[1] ? {junk[31:24], st, junk[15:0]} : {junk[31:8], st};
    m_axi_rresp = (rcnt == rerr_idx) ? 2'b10 : 2'b00;
    m_axi_rvalid = 1'b1;
    rcnt++;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      if (!rst_n) return;
      hs = m_axi_rready;
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0;
    check("r_handshake", hs, 1);
  endtask

  initial begin : slave
    forever begin
      @(negedge clk);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      if (rst_n && (m_axi_awvalid || m_axi_wvalid)) do_write();
      else if (rst_n && m_axi_arvalid) do_read();
    end
  end

  // ---------------- per-cycle checks of handshake-level outputs
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [1:0] p_code;
  logic [7:0] p_status;
  always @(negedge clk) begin
    if (rst_n) begin
      check("prot", {m_axi_awprot, m_axi_arprot}, 6'b0);
      if (chk_ready) check("cmd_ready", cmd_ready, !busy);
      if (!busy) check("rsp_valid_idle", rsp_valid, 0);
      if (p_valid && !p_ready) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_code", rsp_code, p_code);
        check("rsp_hold_status", rsp_status, p_status);
      end
    end
    p_valid = rst_n && rsp_valid;
    p_ready = rsp_ready;
    p_code = rsp_code;
    p_status = rsp_status;
  end

  // ---------------- command driver
  task automatic issue(input logic [1:0] op, input logic [A-1:0] addr, input logic [15:0] d);
    bit acc;
    wcnt = 0; rcnt = 0;
    model(op, addr, d);
    cmd_op = op; cmd_addr = addr; cmd_data = d; cmd_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = cmd_ready;
      tick();
    end
    check("cmd_accept", acc, 1);
    busy = acc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = A'($urandom); cmd_data = 16'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [A-1:0] addr, input logic [15:0] d,
                         input int hold);
    issue(op, addr, d);
    for (int c = 0; c < 3000 && !rsp_valid; c++) tick();
    check("rsp_arrived", rsp_valid, 1);
    check("rsp_code", rsp_code, exp_code);
    check("rsp_status", rsp_status, exp_status);
    check("txns_left", exp_q.size(), 0);
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    busy = 1'b0;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 16; i++) stat_arr[i] = 8'h00;
    berr_idx = -1; rerr_idx = -1; force_late = 1'b0;
  endtask

  initial begin : main
    clear_script();
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                         m_axi_bready, m_axi_rready}, 6'b0);
    check("rst_rsp", {rsp_code, rsp_status}, 10'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", cmd_ready, 1);
    chk_ready = 1'b1;

    // Program, upper lanes, two status reads
    clear_script();
    stat_arr[0] = 8'h00; stat_arr[1] = 8'h80;
    model(2'd1, 27'h0000102, 16'hBEEF);
    check("pin_prog_len", exp_q.size(), 6);
    check("pin_prog_w0", exp_q[0].data, 32'h0050_0000);
    check("pin_prog_w2", exp_q[2].data, 32'hBEEF_0000);
    check("pin_prog_strb", exp_q[2].strb, 4'b1100);
    check("pin_prog_rd", exp_q[4].wr, 0);
    check("pin_prog_ff", exp_q[5].data, 32'h00FF_0000);
    check("pin_prog_rsp", {exp_code, exp_status}, {2'd0, 8'h80});
    run_cmd(2'd1, 27'h0000102, 16'hBEEF, 1);

    // Erase with device error bit
    clear_script();
    stat_arr[0] = 8'hA0;
    model(2'd2, 27'h0020000, 16'h0000);
    check("pin_erase_len", exp_q.size(), 7);
    check("pin_erase_w3", exp_q[3].data, 32'h0000_0020);
    check("pin_erase_rsp", {exp_code, exp_status}, {2'd1, 8'hA0});
    run_cmd(2'd2, 27'h0020000, 16'h1234, 0);

    // Poll timeout
    clear_script();
    model(2'd1, 27'h0000040, 16'h5A5A);
    check("pin_timeout_len", exp_q.size(), 8);
    check("pin_timeout_code", exp_code, 2'd2);
    run_cmd(2'd1, 27'h0000040, 16'h5A5A, 2);

    // bresp error on second write
    clear_script();
    berr_idx = 1;
    model(2'd1, 27'h0000300, 16'h1111);
    check("pin_berr_len", exp_q.size(), 2);
    check("pin_berr_code", exp_code, 2'd3);
    run_cmd(2'd1, 27'h0000300, 16'h1111, 0);

    // Late awready and a stalled response
    clear_script();
    force_late = 1'b1;
    stat_arr[0] = 8'h3C;
    run_cmd(2'd3, 27'h0000002, 16'h0000, 5);

    // Reset asserted mid-poll
    clear_script();
    wcnt = 0; rcnt = 0;
    issue(2'd2, 27'h0001000, 16'h0000);
    for (int c = 0; c < 500 && rcnt < 2; c++) tick();
    check("reached_poll", rcnt >= 2, 1);
    #2;
    rst_n = 1'b0;
    busy = 1'b0;
    chk_ready = 1'b0;
    #1;
    check("midrst_valids", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                            m_axi_bready, m_axi_rready, cmd_ready}, 7'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    check("ready_after_midrst", cmd_ready, 1);
    chk_ready = 1'b1;
    clear_script();
    stat_arr[0] = 8'h80;
    run_cmd(2'd3, 27'h0001000, 16'h0000, 0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      clear_script();
      for (int i = 0; i < 16; i++) begin
        stat_arr[i] = 8'($urandom);
        stat_arr[i][7] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 7) == 0) berr_idx = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) rerr_idx = $urandom_range(0, 3);
      force_late = ($urandom_range(0, 5) == 0);
      run_cmd(2'($urandom), A'($urandom), 16'($urandom), $urandom_range(0, 5));
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
